// File: rtl/lut3_rr_scheduler.sv
// lut3_rr_scheduler: round-robin sharing of one programmable 3-input LUT among N_REQ requesters,
// with a single registered result slot under backpressure and a wrapping evaluation counter.
module lut3_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter logic [7:0] DEFAULT_TABLE = 8'h96,
    parameter int ID_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_table,
    input  logic [N_REQ-1:0]   req,
    input  logic [3*N_REQ-1:0] sel,
    output logic [N_REQ-1:0]   gnt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_id,
    output logic               res_bit,
    output logic [7:0]         table_q,
    output logic [15:0]        eval_count
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] gidx;
    logic            found;
    logic            can_acc;
    logic            acc;
    int              j;

    assign can_acc = !res_valid || res_ready;
    assign acc = |gnt;

    // Scan offsets from farthest to nearest so the nearest requester at or after ptr wins.
    always_comb begin
        gnt = '0;
        gidx = '0;
        found = 1'b0;
        j = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                found = 1'b1;
                gidx = ID_W'(j);
            end
        end
        if (found && can_acc && !reset) gnt[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            table_q <= DEFAULT_TABLE;
            ptr <= '0;
            res_valid <= 1'b0;
            res_id <= '0;
            res_bit <= 1'b0;
            eval_count <= '0;
        end else begin
            if (cfg_we) table_q <= cfg_table;
            if (acc) begin
                ptr <= (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
                res_bit <= table_q[sel[3*gidx +: 3]];
                res_id <= gidx;
                res_valid <= 1'b1;
                eval_count <= eval_count + 16'd1;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lut3_rr_scheduler.sv
// tb_lut3_rr_scheduler: directed checks of arbitration order, backpressure, table config, reset and counter wrap.
module tb_lut3_rr_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [7:0]  cfg_table;
    logic [3:0]  req;
    logic [11:0] sel;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic        res_bit;
    logic [7:0]  table_q;
    logic [15:0] eval_count;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [3:0]  exp_bits;

    lut3_rr_scheduler #(.N_REQ(4), .DEFAULT_TABLE(8'h96), .ID_W(2)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_table(cfg_table),
        .req(req), .sel(sel), .gnt(gnt), .res_valid(res_valid),
        .res_ready(res_ready), .res_id(res_id), .res_bit(res_bit),
        .table_q(table_q), .eval_count(eval_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_table = 8'h00;
        req = 4'b1111; sel = 12'h000; res_ready = 1'b1;
        #1;
        check("gnt_in_reset", 32'(gnt), 32'h0);
        tick();
        reset = 1'b0; req = 4'b0000;
        #1;
        check("rst_valid", 32'(res_valid), 32'h0);
        check("rst_table", 32'(table_q), 32'h96);
        check("rst_count", 32'(eval_count), 32'h0);
        check("rst_id", 32'(res_id), 32'h0);
        check("rst_bit", 32'(res_bit), 32'h0);
        check("idle_gnt", 32'(gnt), 32'h0);

        req = 4'b0001; sel = 12'h003;
        #1 check("t1_gnt", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        check("t1_valid", 32'(res_valid), 32'h1);
        check("t1_id", 32'(res_id), 32'h0);
        check("t1_bit_sel3", 32'(res_bit), 32'h0);
        req = 4'b0001; sel = 12'h007;
        #1 check("t1_gnt2", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        check("t1_bit_sel7", 32'(res_bit), 32'h1);
        check("t1_count", 32'(eval_count), 32'h2);
        tick();
        check("t1_drained", 32'(res_valid), 32'h0);

        // Fresh reset so the pointer starts at 0 and the counter at 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111; sel = {3'b111, 3'b010, 3'b001, 3'b000};
        exp_bits = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
            tick();
            check($sformatf("rr_id%0d", i), 32'(res_id), 32'(i % 4));
            check($sformatf("rr_bit%0d", i), 32'(res_bit), 32'(exp_bits[i % 4]));
        end
        req = 4'b0000;
        check("rr_count", 32'(eval_count), 32'd8);

        res_ready = 1'b0; req = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("bp_gnt%0d", i), 32'(gnt), 32'h0);
            tick();
            check($sformatf("bp_valid%0d", i), 32'(res_valid), 32'h1);
            check($sformatf("bp_id%0d", i), 32'(res_id), 32'h3);
            check($sformatf("bp_bit%0d", i), 32'(res_bit), 32'h1);
            check($sformatf("bp_count%0d", i), 32'(eval_count), 32'd8);
        end
        res_ready = 1'b1;
        #1 check("bp_release_gnt", 32'(gnt), 32'h2);
        tick();
        req = 4'b0000;
        check("bp_new_id", 32'(res_id), 32'h1);
        check("bp_new_bit", 32'(res_bit), 32'h1);
        check("bp_new_count", 32'(eval_count), 32'd9);
        tick();

        req = 4'b0001; sel = 12'h003; cfg_we = 1'b1; cfg_table = 8'hE8;
        #1 check("cfg_gnt", 32'(gnt), 32'h1);
        tick();
        cfg_we = 1'b0; req = 4'b0000;
        check("cfg_old_table", 32'(res_bit), 32'h0);
        check("cfg_table_q", 32'(table_q), 32'hE8);
        req = 4'b0001;
        #1 check("cfg_gnt2", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        check("cfg_new_table", 32'(res_bit), 32'h1);

        res_ready = 1'b0; req = 4'b1000; cfg_we = 1'b1; cfg_table = 8'h00; reset = 1'b1;
        #1 check("rst2_gnt", 32'(gnt), 32'h0);
        tick();
        reset = 1'b0; cfg_we = 1'b0; req = 4'b1001; res_ready = 1'b1;
        check("rst2_valid", 32'(res_valid), 32'h0);
        check("rst2_table", 32'(table_q), 32'h96);
        check("rst2_count", 32'(eval_count), 32'h0);
        #1 check("rst2_ptr_gnt", 32'(gnt), 32'h1);
        tick();
        req = 4'b0000;
        check("rst2_id", 32'(res_id), 32'h0);
        check("rst2_count1", 32'(eval_count), 32'h1);

        req = 4'b0001; sel = 12'h007;
        repeat (65535) tick();
        req = 4'b0000;
        check("wrap_count", 32'(eval_count), 32'h0);
        check("wrap_valid", 32'(res_valid), 32'h1);
        check("wrap_id", 32'(res_id), 32'h0);
        check("wrap_bit", 32'(res_bit), 32'h1);
        check("wrap_table", 32'(table_q), 32'h96);
        tick();
        check("wrap_drained", 32'(res_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/lut3_rr_scheduler.md
# lut3_rr_scheduler

Round-robin scheduler that shares a single programmable 3-input lookup evaluator (8-entry truth table indexed by a 3-bit select) among several requesters. Each requester presents a 3-bit select and receives a one-bit function result tagged with its ID. The truth table is runtime-configurable and defaults to 3-input parity. The block sits between the requesting datapath units and the shared LUT/mux resource, and provides arbitration, result buffering with backpressure, and an evaluation counter.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DEFAULT_TABLE, 8'h96, truth table loaded at reset; bit k = result for select k
- ID_W, 2, width of requester ID (= clog2(N_REQ))
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cfg_we  in  1  load cfg_table into truth-table register
- cfg_table  in  8  new truth table
- req  in  N_REQ  request per requester
- sel  in  3*N_REQ  select of requester i at sel[3i+2:3i]
- gnt  out  N_REQ  one-hot grant, combinational, same cycle as acceptance
- res_valid  out  1  result register holds unconsumed result
- res_ready  in  1  consumer accepts result
- res_id  out  ID_W  ID of requester that produced result
- res_bit  out  1  table[sel of granted requester]
- table_q  out  8  current truth table
- eval_count  out  16  number of evaluations accepted, wraps

## Operation
- Accept condition: can_acc = !res_valid || res_ready. gnt is all-zero when !can_acc, when no req is set, or while reset is high.
- Arbitration: pointer ptr (ID_W bits). Search req cyclically from ptr upward; the first set bit i gets gnt[i]=1. On acceptance, ptr <= (i+1) mod N_REQ. ptr is unchanged when nothing is granted.
- On acceptance: res_bit <= table_q[sel_i], res_id <= i, res_valid <= 1, eval_count <= eval_count+1 (mod 2^16).
- No acceptance but res_valid && res_ready: res_valid <= 0. res_id and res_bit hold their last values.
- res_valid && !res_ready: all result outputs hold, gnt=0, and ptr holds.
- Requester protocol: the requester keeps req and sel stable until it sees gnt. It may drop req at any time before grant with no side effects. Deasserting req in the grant cycle does not occur. If req is still high in the cycle after gnt, that is a new request.
- Config: on cfg_we, table_q <= cfg_table at the clock edge. An evaluation accepted in the same cycle uses the old table_q. cfg_we is independent of backpressure and is never blocked.
- Reset values: table_q=DEFAULT_TABLE, ptr=0, res_valid=0, res_id=0, res_bit=0, eval_count=0. Reset overrides any simultaneous cfg_we, request, or res_ready. A pending unconsumed result is discarded.

## Timing
- Grant to result: 1 cycle. gnt in cycle t, and res_valid/res_bit/res_id are visible in cycle t+1.
- Throughput: 1 evaluation per cycle while res_ready=1 (result consumed and new one accepted in the same cycle).
- Grant is combinational from req, ptr, res_valid, res_ready, and reset. No combinational path exists from sel to any output other than through the registered res_bit.
- Fairness: under persistent requests from all N_REQ requesters, each requester is granted exactly once per N_REQ accepted evaluations.
- Wrap-around: ptr wraps from N_REQ-1 to 0. eval_count wraps from 16'hFFFF to 0.
- Config latency: 1 cycle. The first evaluation that sees the new table is one accepted in a cycle after the cfg_we edge.

## Test plan
- Reset, then req=4'b0001 with sel0=3'b011 and res_ready=1 → gnt=4'b0001 that cycle; next cycle res_valid=1, res_id=0, res_bit=0 (table 8'h96 bit3); sel0=3'b111 → res_bit=1.
- req=4'b1111 held for 8 cycles with res_ready=1 → grant order 0,1,2,3,0,1,2,3, one per cycle; eval_count=8.
- Result pending and res_ready=0 for 3 cycles with req=4'b0110 → gnt=0 and outputs frozen. res_ready=1 → same-cycle gnt=4'b0010 and result replaced next cycle.
- cfg_we=1 with cfg_table=8'hE8 in the same cycle as a grant with sel=3'b011 → res_bit=0 (old table). Next grant with sel=3'b011 → res_bit=1; table_q=8'hE8.
- reset asserted for one cycle while res_valid=1, req=4'b1000, and cfg_we=1 → following cycle res_valid=0, table_q=8'h96, eval_count=0, ptr=0 (next grant from req=4'b1001 goes to 0).
- Force 65536 accepted evaluations → eval_count returns to 0 with no other side effect.
